dac_wave_player: RTL and testbench

- BRAM-backed waveform playback source driving the DAC tile's AXI4-Stream sample input (256-bit s00 path).
- Software/loader side writes up to DEPTH words into an internal buffer, then a start pulse replays the first cfg_len words, cfg_loops times or forever.
- Output is a standard AXIS master with full tready backpressure support, clocked on clk_dac.

---
 rtl/dac_wave_player_if.sv | 11 +
 rtl/dac_wave_player.sv | 143 ++++++++++++++
 tb/tb_dac_wave_player.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dac_wave_player_if.sv
// AXI4-Stream sample channel between the waveform player and the DAC tile.
interface dac_wave_player_if #(
  parameter int unsigned AXIS_WID = 256
);
  logic [AXIS_WID-1:0] tdata;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_wave_player.sv
// Buffered waveform player: replays the first len words of a loadable RAM over AXIS,
// a fixed number of loops or until stopped, through a 2-entry skid FIFO.
module dac_wave_player #(
  parameter int unsigned AXIS_WID = 256,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_WID = 10,
  parameter int unsigned LOOP_WID = 16
) (
  input  logic                clk_dac,
  input  logic                dac_rst,
  input  logic                wr_en,
  input  logic [ADDR_WID-1:0] wr_addr,
  input  logic [AXIS_WID-1:0] wr_data,
  input  logic [ADDR_WID:0]   cfg_len,
  input  logic [LOOP_WID-1:0] cfg_loops,
  input  logic                start,
  input  logic                stop,
  dac_wave_player_if.master   m_axis,
  output logic                busy,
  output logic                done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPlay  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [ADDR_WID:0] LenMax = (ADDR_WID+1)'(DEPTH);
  localparam logic [ADDR_WID:0] LenOne = (ADDR_WID+1)'(1);

  logic [AXIS_WID-1:0] r_mem [DEPTH];

  logic [1:0]          r_state;
  logic [ADDR_WID:0]   r_len;
  logic [LOOP_WID-1:0] r_loops;
  logic [LOOP_WID-1:0] r_loop_cnt;
  logic [ADDR_WID-1:0] r_rd_addr;
  logic [AXIS_WID-1:0] r_fifo [2];
  logic                r_wptr;
  logic                r_rptr;
  logic [1:0]          r_count;
  logic                r_done;

  logic                w_cfg_ok;
  logic                w_pop;
  logic                w_issue;
  logic [ADDR_WID:0]   w_len_m1;
  logic                w_wrap;
  logic [LOOP_WID-1:0] w_loop_nxt;
  logic                w_final;
  logic [1:0]          w_count_d;

  assign w_cfg_ok   = (cfg_len != '0) && (cfg_len <= LenMax);
  assign w_pop      = m_axis.tvalid && m_axis.tready;
  // The RAM read lands straight in a FIFO slot, so occupancy alone gates issue.
  assign w_issue    = (r_state == StPlay) && !stop && (r_count != 2'd2);
  assign w_len_m1   = r_len - LenOne;
  assign w_wrap     = (r_rd_addr == w_len_m1[ADDR_WID-1:0]);
  assign w_loop_nxt = r_loop_cnt + LOOP_WID'(1);
  assign w_final    = w_wrap && (r_loops != '0) && (w_loop_nxt == r_loops);

  always_comb begin
    w_count_d = r_count;
    unique case ({w_issue, w_pop})
      2'b10:   w_count_d = r_count + 2'd1;
      2'b01:   w_count_d = r_count - 2'd1;
      default: w_count_d = r_count;
    endcase
  end

  assign m_axis.tdata  = r_fifo[r_rptr];
  assign m_axis.tvalid = (r_count != 2'd0);
  assign busy          = (r_state != StIdle);
  assign done          = r_done;

  // Buffer contents deliberately survive reset.
  always_ff @(posedge clk_dac) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_dac) begin
    if (dac_rst) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_loops    <= '0;
      r_loop_cnt <= '0;
      r_rd_addr  <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_done     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_count <= w_count_d;
      if (w_issue) begin
        r_fifo[r_wptr] <= r_mem[r_rd_addr];
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end

      case (r_state)
        StIdle: begin
          if (start && w_cfg_ok) begin
            r_len      <= cfg_len;
            r_loops    <= cfg_loops;
            r_loop_cnt <= '0;
            r_rd_addr  <= '0;
            r_state    <= StPlay;
          end
        end
        StPlay: begin
          if (stop) begin
            r_state <= StDrain;
          end else if (w_issue) begin
            if (w_wrap) begin
              r_rd_addr  <= '0;
              r_loop_cnt <= w_loop_nxt;
            end else begin
              r_rd_addr <= r_rd_addr + ADDR_WID'(1);
            end
            if (w_final) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (w_count_d == 2'd0) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed bench for dac_wave_player: loop playback, backpressure, stop, bad config, reset.
module tb_dac_wave_player;

  localparam int unsigned AXIS_WID = 256;
  localparam int unsigned DEPTH    = 1024;
  localparam int unsigned ADDR_WID = 10;
  localparam int unsigned LOOP_WID = 16;

  logic                clk_dac = 1'b0;
  logic                dac_rst;
  logic                wr_en;
  logic [ADDR_WID-1:0] wr_addr;
  logic [AXIS_WID-1:0] wr_data;
  logic [ADDR_WID:0]   cfg_len;
  logic [LOOP_WID-1:0] cfg_loops;
  logic                start;
  logic                stop;
  logic                busy;
  logic                done;

  int n_tests = 0;
  int n_fail  = 0;

  dac_wave_player_if #(.AXIS_WID(AXIS_WID)) axis_if ();

  dac_wave_player #(
    .AXIS_WID(AXIS_WID),
    .DEPTH   (DEPTH),
    .ADDR_WID(ADDR_WID),
    .LOOP_WID(LOOP_WID)
  ) dut (
    .clk_dac  (clk_dac),
    .dac_rst  (dac_rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cfg_len  (cfg_len),
    .cfg_loops(cfg_loops),
    .start    (start),
    .stop     (stop),
    .m_axis   (axis_if),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_dac = ~clk_dac;

  task automatic step();
    @(posedge clk_dac);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [AXIS_WID-1:0] obs,
                      input logic [AXIS_WID-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Consumes nbeats handshakes starting in the current cycle; word k carries value k % len.
  task automatic collect(input int nbeats, input int len, input int first_idx,
                         input bit alt, input bit check_end, output int cycles);
    int               beat = 0;
    int               cyc = 0;
    bit               stalled = 0;
    logic [AXIS_WID-1:0] held = '0;
    while (beat < nbeats && cyc < 200) begin
      axis_if.tready = alt ? (cyc % 2 == 0) : 1'b1;
      chk1("no_early_done", done, 1'b0);
      if (stalled) chkw("stall_hold", axis_if.tdata, held);
      if (axis_if.tvalid && axis_if.tready) begin
        chkw("beat_data", axis_if.tdata, AXIS_WID'((first_idx + beat) % len));
        beat++;
        stalled = 0;
      end else if (axis_if.tvalid) begin
        held    = axis_if.tdata;
        stalled = 1;
      end
      step();
      cyc++;
    end
    axis_if.tready = 1'b1;
    chki("beat_count", beat, nbeats);
    cycles = cyc;
    if (check_end) begin
      chk1("done_after_last", done, 1'b1);
      chk1("busy_low_at_done", busy, 1'b0);
      step();
      chk1("done_one_cycle", done, 1'b0);
      chk1("tvalid_idle", axis_if.tvalid, 1'b0);
    end
  endtask

  task automatic stop_and_drain(input int next_idx, input int len);
    int extra = 0;
    int cyc = 0;
    bit seen_done = 0;
    stop = 1'b1;
    while (!seen_done && cyc < 20) begin
      if (axis_if.tvalid) begin
        chkw("drain_data", axis_if.tdata, AXIS_WID'((next_idx + extra) % len));
        extra++;
      end
      step();
      stop = 1'b0;
      cyc++;
      if (done) seen_done = 1;
    end
    chk1("drain_done_seen", seen_done, 1'b1);
    chk1("drain_extra_le2", extra <= 2, 1'b1);
    chk1("drain_busy_low", busy, 1'b0);
    step();
    chk1("drain_done_once", done, 1'b0);
    chk1("drain_tvalid_low", axis_if.tvalid, 1'b0);
    chk1("drain_busy_stays", busy, 1'b0);
  endtask

  task automatic kick(input int len, input int loops, input logic stp);
    cfg_len   = (ADDR_WID+1)'(len);
    cfg_loops = LOOP_WID'(loops);
    start     = 1'b1;
    stop      = stp;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int cycles;
    dac_rst        = 1'b1;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    cfg_len        = '0;
    cfg_loops      = '0;
    start          = 1'b0;
    stop           = 1'b0;
    axis_if.tready = 1'b1;
    repeat (3) step();
    dac_rst = 1'b0;
    step();

    chk1("rst_tvalid", axis_if.tvalid, 1'b0);
    chkw("rst_tdata", axis_if.tdata, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_WID'(i);
      wr_data = AXIS_WID'(i);
      step();
    end
    wr_en = 1'b0;
    step();

    // len=4, loops=2, full rate: exact latency and back-to-back beats.
    kick(4, 2, 1'b0);
    chk1("t1_busy_t1", busy, 1'b1);
    chk1("t1_tvalid_t1", axis_if.tvalid, 1'b0);
    step();
    chk1("t1_tvalid_t2", axis_if.tvalid, 1'b1);
    collect(8, 4, 0, 1'b0, 1'b1, cycles);
    chki("t1_consecutive", cycles, 8);

    // Alternating tready.
    kick(4, 2, 1'b0);
    collect(8, 4, 0, 1'b1, 1'b1, cycles);

    // Single-word loop, three times.
    kick(1, 3, 1'b0);
    collect(3, 1, 0, 1'b0, 1'b1, cycles);

    // Infinite loop stopped after 10 handshakes.
    kick(4, 0, 1'b0);
    collect(10, 4, 0, 1'b0, 1'b0, cycles);
    stop_and_drain(10, 4);

    // Invalid lengths are ignored.
    kick(0, 1, 1'b0);
    chk1("len0_busy", busy, 1'b0);
    step();
    chk1("len0_tvalid", axis_if.tvalid, 1'b0);
    chk1("len0_done", done, 1'b0);
    kick(DEPTH + 1, 1, 1'b0);
    chk1("lenbig_busy", busy, 1'b0);
    step();
    chk1("lenbig_tvalid", axis_if.tvalid, 1'b0);
    chk1("lenbig_done", done, 1'b0);

    // Start and stop together in idle: start wins.
    kick(4, 1, 1'b1);
    chk1("startstop_busy", busy, 1'b1);
    collect(4, 4, 0, 1'b0, 1'b1, cycles);

    // Reset mid-stream, then replay from word 0.
    kick(4, 0, 1'b0);
    collect(5, 4, 0, 1'b0, 1'b0, cycles);
    dac_rst = 1'b1;
    step();
    dac_rst = 1'b0;
    chk1("rst_mid_tvalid", axis_if.tvalid, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_done", done, 1'b0);
    step();
    chk1("rst_mid_done2", done, 1'b0);
    chk1("rst_mid_tvalid2", axis_if.tvalid, 1'b0);
    kick(4, 0, 1'b0);
    collect(6, 4, 0, 1'b0, 1'b0, cycles);
    stop_and_drain(6, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
